// File: rtl/sub_pipe_pkg.sv
// rtl/sub_pipe_pkg.sv - shared defaults, entry type and output packing for the subtractor result path
package sub_pipe_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ACC_W  = 8;
    localparam int OUT_W      = 8;

    typedef struct packed {
        logic                  borrow;
        logic [DEF_DATA_W-1:0] diff;
    } sub_entry_t;

    // Consumer sees the entry right-aligned in a byte: {3'b000, borrow, diff}.
    function automatic logic [OUT_W-1:0] pack_out(input sub_entry_t e);
        return {3'b000, e.borrow, e.diff};
    endfunction

endpackage

// File: rtl/sub_fifo_mem.sv
// rtl/sub_fifo_mem.sv - DEPTH x sub_entry_t register file, one write port, one async read port
module sub_fifo_mem
    import sub_pipe_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  sub_entry_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output sub_entry_t        rdata
);

    // Storage is deliberately unreset; the owner masks reads while empty.
    sub_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sub_result_fifo.sv
// rtl/sub_result_fifo.sv - buffers subtractor results for an 8-bit valid/ready drain port
// Optional signed saturating running sum of accepted results when DIFF_ACC_EN is defined.
module sub_result_fifo
    import sub_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_diff,
    input  logic                     in_borrow,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [ACC_W-1:0]         acc_sum
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    sub_entry_t       wr_entry;
    sub_entry_t       head;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = in_valid & ~full;
    assign pop   = ~empty & out_ready;

    assign wr_entry.borrow = in_borrow;
    assign wr_entry.diff   = in_diff;

    sub_fifo_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk  (clk),
        .we   (push & ~clear),
        .waddr(wr_ptr),
        .wdata(wr_entry),
        .raddr(rd_ptr),
        .rdata(head)
    );

    // Pointers wrap naturally at DEPTH (power of two); count alone decides full/empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (in_valid && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : pack_out(head);
    assign count     = cnt_q;
    assign overflow  = ovf_q;

`ifdef DIFF_ACC_EN
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   acc_wide;
    logic [ACC_W-1:0] acc_next;

    // One guard bit catches overflow; {borrow,diff} is sign-extended as a (DATA_W+1)-bit value.
    always_comb begin
        acc_wide = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W-DATA_W){in_borrow}}, in_borrow, in_diff};
        case (acc_wide[ACC_W:ACC_W-1])
            2'b01:   acc_next = {1'b0, {(ACC_W-1){1'b1}}};
            2'b10:   acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            default: acc_next = acc_wide[ACC_W-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (push) begin
            acc_q <= acc_next;
        end
    end

    assign acc_sum = acc_q;
`else
    assign acc_sum = '0;
`endif

endmodule

// File: tb/tb_sub_result_fifo.sv
// tb/tb_sub_result_fifo.sv - self-checking bench for sub_result_fifo
module tb_sub_result_fifo;
    import sub_pipe_pkg::*;

    localparam int CNT_W = 3;
    localparam int ACC_W = 8;
    localparam int NVEC  = 21;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic [3:0]       in_diff;
    logic             in_borrow;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [ACC_W-1:0] acc_sum;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sub_result_fifo #(.DATA_W(4), .DEPTH(4), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_diff  (in_diff),
        .in_borrow(in_borrow),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count),
        .overflow (overflow),
        .acc_sum  (acc_sum)
    );

    typedef struct {
        logic       clr;
        logic       vld;
        logic [3:0] diff;
        logic       brw;
        logic       ordy;
        logic [2:0] exp_cnt;
        logic       exp_ovalid;
        logic       exp_irdy;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic v, input logic [3:0] d, input logic b, input logic r);
        clear     = c;
        in_valid  = v;
        in_diff   = d;
        in_borrow = b;
        out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected state after each vector's clock edge.
        //            clr  vld  diff  brw  ordy  cnt ovld irdy data   ovf
        vecs[0]  = '{1'b0,1'b1,4'h4,1'b0,1'b0, 3'd1,1'b1,1'b1,8'h04,1'b0}; // 9-5
        vecs[1]  = '{1'b0,1'b1,4'hC,1'b1,1'b0, 3'd2,1'b1,1'b1,8'h04,1'b0}; // 3-7, head stable
        vecs[2]  = '{1'b0,1'b0,4'h0,1'b0,1'b1, 3'd1,1'b1,1'b1,8'h1C,1'b0};
        vecs[3]  = '{1'b0,1'b0,4'h0,1'b0,1'b1, 3'd0,1'b0,1'b1,8'h00,1'b0};
        vecs[4]  = '{1'b0,1'b0,4'h0,1'b0,1'b1, 3'd0,1'b0,1'b1,8'h00,1'b0}; // pop on empty ignored
        vecs[5]  = '{1'b0,1'b1,4'h1,1'b0,1'b0, 3'd1,1'b1,1'b1,8'h01,1'b0};
        vecs[6]  = '{1'b0,1'b1,4'h2,1'b0,1'b0, 3'd2,1'b1,1'b1,8'h01,1'b0};
        vecs[7]  = '{1'b0,1'b1,4'h3,1'b0,1'b0, 3'd3,1'b1,1'b1,8'h01,1'b0};
        vecs[8]  = '{1'b0,1'b1,4'h4,1'b0,1'b0, 3'd4,1'b1,1'b0,8'h01,1'b0};
        vecs[9]  = '{1'b0,1'b1,4'h5,1'b0,1'b0, 3'd4,1'b1,1'b0,8'h01,1'b1}; // dropped
        vecs[10] = '{1'b0,1'b0,4'h0,1'b0,1'b0, 3'd4,1'b1,1'b0,8'h01,1'b1}; // sticky
        vecs[11] = '{1'b0,1'b1,4'h6,1'b0,1'b1, 3'd3,1'b1,1'b1,8'h02,1'b1}; // full push+pop
        vecs[12] = '{1'b0,1'b0,4'h0,1'b0,1'b1, 3'd2,1'b1,1'b1,8'h03,1'b1};
        vecs[13] = '{1'b0,1'b0,4'h0,1'b0,1'b1, 3'd1,1'b1,1'b1,8'h04,1'b1};
        vecs[14] = '{1'b0,1'b0,4'h0,1'b0,1'b1, 3'd0,1'b0,1'b1,8'h00,1'b1};
        vecs[15] = '{1'b0,1'b1,4'h7,1'b1,1'b0, 3'd1,1'b1,1'b1,8'h17,1'b1};
        vecs[16] = '{1'b0,1'b1,4'h9,1'b0,1'b1, 3'd1,1'b1,1'b1,8'h09,1'b1}; // one-entry push+pop
        vecs[17] = '{1'b0,1'b0,4'h0,1'b0,1'b1, 3'd0,1'b0,1'b1,8'h00,1'b1};
        vecs[18] = '{1'b1,1'b1,4'hA,1'b0,1'b0, 3'd0,1'b0,1'b1,8'h00,1'b0}; // clear beats push
        vecs[19] = '{1'b0,1'b1,4'h3,1'b0,1'b0, 3'd1,1'b1,1'b1,8'h03,1'b0};
        vecs[20] = '{1'b1,1'b1,4'h8,1'b1,1'b1, 3'd0,1'b0,1'b1,8'h00,1'b0}; // clear beats push+pop

        rst = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.count", count, 3'd0);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.in_ready", in_ready, 1'b1);
        check("reset.out_data", out_data, 8'h00);
        rst = 1'b0;

        // Asynchronous reset while three entries are queued.
        drive(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 4'h2, 1'b1, 1'b0);
        step();
        check("pre_rst.count", count, 3'd3);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst.count", count, 3'd0);
        check("async_rst.out_valid", out_valid, 1'b0);
        check("async_rst.overflow", overflow, 1'b0);
        check("async_rst.out_data", out_data, 8'h00);
        check("async_rst.acc_sum", acc_sum, 8'h00);
        step();
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].clr, vecs[i].vld, vecs[i].diff, vecs[i].brw, vecs[i].ordy);
            step();
            check($sformatf("v%0d.count", i), count, vecs[i].exp_cnt);
            check($sformatf("v%0d.out_valid", i), out_valid, vecs[i].exp_ovalid);
            check($sformatf("v%0d.in_ready", i), in_ready, vecs[i].exp_irdy);
            check($sformatf("v%0d.out_data", i), out_data, vecs[i].exp_data);
            check($sformatf("v%0d.overflow", i), overflow, vecs[i].exp_ovf);
`ifndef DIFF_ACC_EN
            check($sformatf("v%0d.acc_sum", i), acc_sum, 8'h00);
`endif
        end

`ifdef DIFF_ACC_EN
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step();
        check("acc.cleared", acc_sum, 8'h00);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
            step();
            if (i == 0) check("acc.first", acc_sum, 8'd15);
        end
        check("acc.pos_sat", acc_sum, 8'd127);
        check("acc.pos_count", count, 3'd1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 4'h1, 1'b1, 1'b1);
            step();
            if (i == 0) check("acc.first_neg", acc_sum, 8'd112);
        end
        check("acc.neg_sat", acc_sum, 8'h80);
        drive(1'b1, 1'b1, 4'h5, 1'b0, 1'b1);
        step();
        check("acc.clear_sum", acc_sum, 8'h00);
        check("acc.clear_count", count, 3'd0);
`endif

        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
